// File: rtl/sysbus_pkg.sv
// sysbus_pkg -- shared types and constants for the system-bus memory responder.
//
// Contents:
//   state_t            responder FSM states (ST_WACK exists only when
//                      SYSBUS_WRITE_RESP_EN is defined)
//   TAG_DIR_BIT        direction bit of the default-width tag (MSB)
//   TAG_READ/TAG_WRITE direction bit values
//   LINE_BEATS_DEFAULT beats per cache line
//   LINE_OFS_W         beat-index width within a line
//   WORD_OFS_W         byte-offset width within one 64-bit bus word
//
// Optional feature macro: SYSBUS_WRITE_RESP_EN (adds the write-response state).

package sysbus_pkg;

`ifdef SYSBUS_WRITE_RESP_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RRESP = 3'd4,
    ST_WACK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACK   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RRESP = 3'd4
  } state_t;
`endif

  localparam int   TAG_WIDTH_DEFAULT  = 13;
  localparam int   TAG_DIR_BIT        = TAG_WIDTH_DEFAULT - 1;
  localparam logic TAG_READ           = 1'b1;
  localparam logic TAG_WRITE          = 1'b0;
  localparam int   LINE_BEATS_DEFAULT = 8;
  localparam int   LINE_OFS_W         = $clog2(LINE_BEATS_DEFAULT);
  localparam int   WORD_OFS_W         = 3;

endpackage

// File: rtl/sysbus_mem_array.sv
// sysbus_mem_array -- single-port word array behind the bus responder.
// One shared address; write is synchronous, read is combinational so the
// responder sees data for its registered index in the same cycle.
// Contents are never cleared.
//
// Ports:
//   clk      clock
//   i_we     write enable (write i_wdata at i_addr on the rising edge)
//   i_addr   word index, shared by read and write
//   i_wdata  write data
//   o_rdata  data at i_addr (combinational)

module sysbus_mem_array #(
  parameter int DATA_W = 64,
  parameter int WORDS  = 4096
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder -- memory-side responder of the system bus.
// Accepts one line-sized READ or WRITE at a time, stores beats in an internal
// word array and streams read lines back with the request tag echoed.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high
//   bus_reqcyc   request header / write beat valid
//   bus_req      header address or write beat data
//   bus_reqtag   request tag (MSB: 1=READ, 0=WRITE), valid with header
//   bus_respack  initiator accepts the current response beat
//   bus_reqack   header accepted (ACK pulse) / write beats accepted (WDATA level)
//   bus_respcyc  response beat valid
//   bus_resp     response data
//   bus_resptag  echoed request tag
//
// Optional feature macro: SYSBUS_WRITE_RESP_EN -- a completed write line
// returns one zero-data response beat carrying the tag (state WACK).
//
// state | meaning
// IDLE  | waiting for a header; latches line base and tag
// ACK   | one-cycle header acknowledge; selects write or read path
// WDATA | accepting write beats (reqcyc low cycles are bubbles)
// RWAIT | read latency countdown
// RRESP | streaming read beats, advancing only on respack
// WACK  | write response beat held until respack (feature builds only)

module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = TAG_DIR_BIT + 1,
  parameter int LINE_BEATS     = LINE_BEATS_DEFAULT,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respack,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int OFS_W  = $clog2(LINE_BEATS);
  localparam int LINE_W = AW - OFS_W;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int DIR    = BUS_TAG_WIDTH - 1;

  localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(LINE_BEATS - 1);
  localparam logic [OFS_W-1:0] BEAT_ONE  = OFS_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [LINE_W-1:0]         r_line;
  logic [OFS_W-1:0]          r_beat;
  logic [BUS_TAG_WIDTH-1:0]  r_tag;
  logic [LAT_W-1:0]          r_lat;

  logic                      w_wr_beat;
  logic                      w_rd_beat;
  logic                      w_last_beat;
  logic                      w_we;
  logic [AW-1:0]             w_addr;
  logic [BUS_DATA_WIDTH-1:0] w_rdata;

  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_wr_beat   = (r_state == ST_WDATA) && bus_reqcyc;
  assign w_rd_beat   = (r_state == ST_RRESP) && bus_respack;
  // A reset arriving with a beat on the bus abandons that beat too.
  assign w_we        = w_wr_beat && !reset;
  assign w_addr      = {r_line, r_beat};

  sysbus_mem_array #(
    .DATA_W (BUS_DATA_WIDTH),
    .WORDS  (MEM_WORDS)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (bus_req),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus_reqcyc) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        w_state_nxt = (r_tag[DIR] == TAG_READ) ? ST_RWAIT : ST_WDATA;
      end
      ST_WDATA: begin
        if (w_wr_beat && w_last_beat) begin
`ifdef SYSBUS_WRITE_RESP_EN
          w_state_nxt = ST_WACK;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_RWAIT: begin
        if (r_lat == LAT_ONE) w_state_nxt = ST_RRESP;
      end
      ST_RRESP: begin
        if (w_rd_beat && w_last_beat) w_state_nxt = ST_IDLE;
      end
`ifdef SYSBUS_WRITE_RESP_EN
      ST_WACK: begin
        if (bus_respack) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    case (r_state)
      ST_ACK, ST_WDATA: begin
        bus_reqack = 1'b1;
      end
      ST_RRESP: begin
        bus_respcyc = 1'b1;
        bus_resp    = w_rdata;
        bus_resptag = r_tag;
      end
`ifdef SYSBUS_WRITE_RESP_EN
      ST_WACK: begin
        bus_respcyc = 1'b1;
        bus_resptag = r_tag;
      end
`endif
      default: begin
      end
    endcase
  end

  // Address keeps only the in-array line index: byte offset and beat offset
  // drop out at the bottom, bits above the array depth alias (wrap).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line <= '0;
      r_beat <= '0;
      r_tag  <= '0;
      r_lat  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus_reqcyc) begin
            r_line <= bus_req[AW+WORD_OFS_W-1 -: LINE_W];
            r_tag  <= bus_reqtag;
            r_beat <= '0;
          end
        end
        ST_ACK: begin
          r_lat <= LAT_LOAD;
        end
        ST_WDATA: begin
          if (w_wr_beat) r_beat <= w_last_beat ? '0 : r_beat + BEAT_ONE;
        end
        ST_RWAIT: begin
          r_lat <= r_lat - LAT_ONE;
        end
        ST_RRESP: begin
          if (w_rd_beat) r_beat <= w_last_beat ? '0 : r_beat + BEAT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line writes (with and without
// bubbles), read-back with latency and backpressure, address wrap, ignored
// second header, and reset in the middle of a write.

module tb_sysbus_mem_responder;

  localparam int DW  = 64;
  localparam int TW  = 13;
  localparam int LAT = 4;

  logic          clk;
  logic          reset;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_respack;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] d_a [8];
  logic [DW-1:0] d_b [8];
  logic [DW-1:0] d_c [8];
  logic [DW-1:0] d_d [8];
  logic [DW-1:0] d_e [8];
  logic [DW-1:0] e_mix [8];

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .LINE_BEATS     (8),
    .MEM_WORDS      (4096),
    .READ_LATENCY   (LAT)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respack (bus_respack),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  // Starts in IDLE; ends in IDLE after a full line, or in WDATA after a partial one.
  task automatic write_line(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input logic [DW-1:0] d [8], input int bubble_at,
                            input int bubble_len, input int nbeats);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = tag;
    chk("wr_hdr_idle", bus_reqack, 0);
    step();
    bus_reqcyc = 1'b0;
    chk("wr_hdr_ack", bus_reqack, 1);
    step();
    for (int k = 0; k < nbeats; k++) begin
      if (k == bubble_at) begin
        for (int b = 0; b < bubble_len; b++) begin
          bus_reqcyc = 1'b0;
          chk("wr_bubble_ack", bus_reqack, 1);
          step();
        end
      end
      bus_reqcyc = 1'b1;
      bus_req    = d[k];
      chk("wr_beat_ack", bus_reqack, 1);
      step();
    end
    bus_reqcyc = 1'b0;
    if (nbeats == 8) begin
`ifdef SYSBUS_WRITE_RESP_EN
      bus_respack = 1'b0;
      chk("wack_cyc", bus_respcyc, 1);
      chk("wack_data", bus_resp, 0);
      chk("wack_tag", bus_resptag, tag);
      for (int h = 0; h < 2; h++) begin
        step();
        chk("wack_hold_cyc", bus_respcyc, 1);
        chk("wack_hold_tag", bus_resptag, tag);
      end
      bus_respack = 1'b1;
      step();
      bus_respack = 1'b0;
`endif
      chk("wr_done_ack", bus_reqack, 0);
      chk("wr_done_cyc", bus_respcyc, 0);
    end
  endtask

  // Starts in IDLE; checks latency, every beat, tag echo, optional stall and
  // optional second header held (and ignored) during the response.
  task automatic read_line(input logic [63:0] addr, input logic [TW-1:0] tag,
                           input logic [DW-1:0] e [8], input int stall_beat,
                           input int stall_len, input bit hold,
                           input logic [63:0] nxt_addr, input logic [TW-1:0] nxt_tag);
    int n;
    bus_reqcyc  = 1'b1;
    bus_req     = addr;
    bus_reqtag  = tag;
    bus_respack = 1'b1;
    step();
    bus_reqcyc = 1'b0;
    chk("rd_hdr_ack", bus_reqack, 1);
    n = 1;
    while (bus_respcyc !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("rd_latency", 64'(n), 64'(LAT + 2));
    for (int k = 0; k < 8; k++) begin
      if (hold) begin
        bus_reqcyc = 1'b1;
        bus_req    = nxt_addr;
        bus_reqtag = nxt_tag;
        chk("rd_ignore_hdr", bus_reqack, 0);
      end
      chk("rd_cyc", bus_respcyc, 1);
      chk("rd_data", bus_resp, e[k]);
      chk("rd_tag", bus_resptag, tag);
      if (k == stall_beat) begin
        bus_respack = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk("rd_stall_data", bus_resp, e[k]);
          chk("rd_stall_cyc", bus_respcyc, 1);
        end
        bus_respack = 1'b1;
      end
      step();
    end
    bus_respack = 1'b0;
    chk("rd_done_cyc", bus_respcyc, 0);
    chk("rd_done_data", bus_resp, 0);
  endtask

  initial begin
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d_a[k] = 64'h11 * 64'(k + 1);
      d_b[k] = 64'hB000_0000_0000_0100 + 64'(k);
      d_c[k] = 64'hC0DE_0000_0000_0000 + 64'(3 * k);
      d_d[k] = 64'h7 * 64'(k + 1);
      d_e[k] = 64'h900 * 64'(k + 1);
      e_mix[k] = (k < 3) ? d_e[k] : d_d[k];
    end
    repeat (3) step();
    chk("rst_reqack", bus_reqack, 0);
    chk("rst_respcyc", bus_respcyc, 0);
    chk("rst_resp", bus_resp, 0);
    chk("rst_resptag", bus_resptag, 0);
    reset = 1'b0;
    step();

    // Line at word 512: write, then read back via an unaligned address with a stall on beat 2.
    write_line(64'h1000, 13'h0042, d_a, -1, 0, 8);
    read_line(64'h1008, 13'h1042, d_a, 2, 3, 1'b0, 64'h0, 13'h0);

    // Two-cycle bubble before beat 5.
    write_line(64'h2000, 13'h0007, d_b, 5, 2, 8);
    read_line(64'h2000, 13'h1001, d_b, -1, 0, 1'b0, 64'h0, 13'h0);

    // 0x8000 aliases line 0; a second header held during the response waits for IDLE.
    write_line(64'h0000, 13'h0003, d_c, -1, 0, 8);
    read_line(64'h8000, 13'h1FFF, d_c, -1, 0, 1'b1, 64'h2000, 13'h1111);
    read_line(64'h2000, 13'h1111, d_b, -1, 0, 1'b0, 64'h0, 13'h0);

    // Reset after three beats of a rewrite: beats 0..2 new, 3..7 keep old line.
    write_line(64'h3000, 13'h0009, d_d, -1, 0, 8);
    write_line(64'h3000, 13'h000A, d_e, -1, 0, 3);
    reset = 1'b1;
    step();
    chk("midrst_reqack", bus_reqack, 0);
    chk("midrst_respcyc", bus_respcyc, 0);
    chk("midrst_resp", bus_resp, 0);
    chk("midrst_resptag", bus_resptag, 0);
    reset = 1'b0;
    step();
    read_line(64'h3000, 13'h1003, e_mix, -1, 0, 1'b0, 64'h0, 13'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
